// File: rtl/lbm_step_sequencer.sv
// Lattice-Boltzmann time-step sequencer: raster-walks a GRID_W x GRID_H lattice (collide, then stream) for MAX_TIME steps.
// Optional macro LBM_SEQ_PAUSE_EN adds an i_pause input that holds off node issue between transfers.
module lbm_step_sequencer #(
  parameter int GRID_W   = 4,
  parameter int GRID_H   = 4,
  parameter int MAX_TIME = 8,
  localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1,
  localparam int YW = (GRID_H > 1) ? $clog2(GRID_H) : 1,
  localparam int TW = $clog2(MAX_TIME)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_node_ack,
`ifdef LBM_SEQ_PAUSE_EN
  input  logic          i_pause,
`endif
  output logic          o_node_valid,
  output logic [XW-1:0] o_node_x,
  output logic [YW-1:0] o_node_y,
  output logic          o_phase,
  output logic          o_step_done,
  output logic [TW:0]   o_time_count,
  output logic          o_busy,
  output logic          o_done
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_COLLIDE  = 3'd1,
    S_STREAM   = 3'd2,
    S_STEP_END = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [XW-1:0] X_LAST = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(GRID_H - 1);
  localparam logic [TW:0]   T_MAX  = (TW+1)'(MAX_TIME);

  state_t          r_state;
  logic            r_valid;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic            r_phase;
  logic            r_step_done;
  logic [TW:0]     r_time;
  logic            r_busy;
  logic            r_done;

  logic            w_pause;
  logic            w_xfer;
  logic            w_x_last;
  logic            w_y_last;

`ifdef LBM_SEQ_PAUSE_EN
  assign w_pause = i_pause;
`else
  assign w_pause = 1'b0;
`endif

  // Ack is only meaningful while a node is offered.
  assign w_xfer   = r_valid & i_node_ack;
  assign w_x_last = (r_x == X_LAST);
  assign w_y_last = (r_y == Y_LAST);

  // Sequencer FSM with all outputs held in registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_valid     <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_phase     <= 1'b0;
      r_step_done <= 1'b0;
      r_time      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_step_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state <= S_COLLIDE;
            r_valid <= ~w_pause;
            r_x     <= '0;
            r_y     <= '0;
            r_phase <= 1'b0;
            r_time  <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        S_COLLIDE, S_STREAM: begin
          if (w_xfer) begin
            if (!w_x_last) begin
              r_x     <= r_x + XW'(1);
              r_valid <= ~w_pause;
            end else if (!w_y_last) begin
              r_x     <= '0;
              r_y     <= r_y + YW'(1);
              r_valid <= ~w_pause;
            end else if (r_state == S_COLLIDE) begin
              // Last collide node: stream starts next cycle with no bubble.
              r_x     <= '0;
              r_y     <= '0;
              r_state <= S_STREAM;
              r_phase <= 1'b1;
              r_valid <= ~w_pause;
            end else begin
              r_x         <= '0;
              r_y         <= '0;
              r_state     <= S_STEP_END;
              r_phase     <= 1'b0;
              r_valid     <= 1'b0;
              r_step_done <= 1'b1;
              r_time      <= (r_time == T_MAX) ? r_time : r_time + (TW+1)'(1);
            end
          end else if (!r_valid) begin
            // A node already offered is never withdrawn; pause only gates a new offer.
            r_valid <= ~w_pause;
          end
        end
        S_STEP_END: begin
          if (r_time == T_MAX) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_COLLIDE;
            r_phase <= 1'b0;
            r_valid <= ~w_pause;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_x     <= '0;
          r_y     <= '0;
          r_phase <= 1'b0;
          r_time  <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_node_valid = r_valid;
  assign o_node_x     = r_x;
  assign o_node_y     = r_y;
  assign o_phase      = r_phase;
  assign o_step_done  = r_step_done;
  assign o_time_count = r_time;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_lbm_step_sequencer.sv
// Directed bench for lbm_step_sequencer: 4x2/MAX_TIME=3 instance with a transfer scoreboard, plus a 1x1/MAX_TIME=1 instance.
module tb_lbm_step_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, ack;
  logic       start1;
  logic       ack1 = 1'b1;
`ifdef LBM_SEQ_PAUSE_EN
  logic       pause = 1'b0;
  logic       pause1 = 1'b0;
`endif

  logic       o_node_valid, o_phase, o_step_done, o_busy, o_done;
  logic [1:0] o_node_x;
  logic [0:0] o_node_y;
  logic [2:0] o_time_count;

  logic       o1_node_valid, o1_phase, o1_step_done, o1_busy, o1_done;
  logic [0:0] o1_node_x, o1_node_y;
  logic [0:0] o1_time_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int exp_q[$];
  int sd_cyc[$];

  always #5 clk = ~clk;

  lbm_step_sequencer #(.GRID_W(4), .GRID_H(2), .MAX_TIME(3)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_node_ack(ack),
`ifdef LBM_SEQ_PAUSE_EN
    .i_pause(pause),
`endif
    .o_node_valid(o_node_valid), .o_node_x(o_node_x), .o_node_y(o_node_y),
    .o_phase(o_phase), .o_step_done(o_step_done), .o_time_count(o_time_count),
    .o_busy(o_busy), .o_done(o_done)
  );

  lbm_step_sequencer #(.GRID_W(1), .GRID_H(1), .MAX_TIME(1)) u_one (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_node_ack(ack1),
`ifdef LBM_SEQ_PAUSE_EN
    .i_pause(pause1),
`endif
    .o_node_valid(o1_node_valid), .o_node_x(o1_node_x), .o_node_y(o1_node_y),
    .o_phase(o1_phase), .o_step_done(o1_step_done), .o_time_count(o1_time_count),
    .o_busy(o1_busy), .o_done(o1_done)
  );

  function automatic int enc(input int ph, input int y, input int x);
    return ph * 256 + y * 16 + x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push_phase(input int ph);
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 4; x++)
        exp_q.push_back(enc(ph, y, x));
  endtask

  // One clock: drive at negedge, score any transfer about to happen, return just after posedge.
  task automatic tick(input logic a, input logic s, input logic s_in_stream);
    @(negedge clk);
    ack   = a;
    start = s | (s_in_stream & o_node_valid & o_phase);
    if (o_node_valid && a) begin
      if (exp_q.size() == 0) chk("xfer_unexpected", exp_q.size(), 1);
      else chk("xfer_order", enc(o_phase, o_node_y, o_node_x), exp_q.pop_front());
    end
    if (o_step_done) begin
      sd_cyc.push_back(cyc);
      chk("tc_at_step_done", o_time_count, sd_cyc.size());
      chk("valid_in_step_end", o_node_valid, 0);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  int  c0;
  bit  stalled;
  bit  hit;

  initial begin
    rst = 1'b1; start = 1'b0; ack = 1'b0; start1 = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("rst_valid", o_node_valid, 0);
    chk("rst_addr", {o_phase, o_node_y, o_node_x}, 0);
    chk("rst_time", o_time_count, 0);
    chk("rst_flags", {o_step_done, o_busy, o_done}, 0);
    rst = 1'b0;

    // Ack while idle must not move anything.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
    chk("idle_ignore_ack", {o_busy, o_node_valid, o_node_y, o_node_x}, 0);

    // Run 1: three steps, 5-cycle stall at collide (2,1), Start asserted during stream.
    for (int s = 0; s < 3; s++) begin push_phase(0); push_phase(1); end
    tick(1'b1, 1'b1, 1'b0);
    chk("start_valid", o_node_valid, 1);
    chk("start_busy", {o_busy, o_done}, 2'b10);
    stalled = 1'b0;
    while (!o_done && cyc < 400) begin
      if (!stalled && o_node_valid && !o_phase && o_node_x == 2'd2 && o_node_y == 1'b1) begin
        stalled = 1'b1;
        for (int k = 0; k < 5; k++) begin
          tick(1'b0, 1'b0, 1'b0);
          chk("stall_valid", o_node_valid, 1);
          chk("stall_addr", {o_phase, o_node_y, o_node_x}, {1'b0, 1'b1, 2'd2});
        end
      end else begin
        tick(1'b1, 1'b0, 1'b1);
      end
    end
    chk("stall_hit", stalled, 1);
    chk("run1_done", {o_done, o_busy}, 2'b10);
    chk("run1_time", o_time_count, 3);
    chk("run1_q_empty", exp_q.size(), 0);
    chk("run1_steps", sd_cyc.size(), 3);
    chk("step_spacing_12", sd_cyc[1] - sd_cyc[0], 17);
    chk("step_spacing_23", sd_cyc[2] - sd_cyc[1], 17);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0);
    chk("done_hold", {o_done, o_time_count, o_node_valid}, {1'b1, 3'd3, 1'b0});

    // Run 2: restart from DONE, then reset at stream node (1,0) of step 2.
    sd_cyc.delete();
    push_phase(0); push_phase(1); push_phase(0);
    exp_q.push_back(enc(1, 0, 0));
    c0 = cyc;
    tick(1'b1, 1'b1, 1'b0);
    chk("restart_time", o_time_count, 0);
    chk("restart_addr", {o_node_valid, o_phase, o_node_y, o_node_x}, {1'b1, 1'b0, 1'b0, 2'd0});
    chk("restart_flags", {o_busy, o_done}, 2'b10);
    hit = 1'b0;
    while (!hit && cyc < c0 + 200) begin
      tick(1'b1, 1'b0, 1'b0);
      hit = o_node_valid && o_phase && o_node_x == 2'd1 && o_node_y == 1'b0 && o_time_count == 3'd1;
    end
    chk("first_step_latency", sd_cyc[0] - c0, 17);
    chk("abort_point_hit", hit, 1);
    rst = 1'b1;
    #1;
    chk("abort_outputs", {o_node_valid, o_phase, o_node_y, o_node_x, o_time_count}, 0);
    chk("abort_flags", {o_step_done, o_busy, o_done}, 0);
    chk("abort_q_empty", exp_q.size(), 0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
    chk("abort_no_step_done", sd_cyc.size(), 1);
    chk("abort_idle", {o_busy, o_done, o_node_valid, o_time_count}, 0);

    // 1x1 lattice, one step: collide, stream, step end, done.
    start1 = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    start1 = 1'b0;
    chk("one_collide", {o1_node_valid, o1_phase, o1_busy}, 3'b101);
    tick(1'b0, 1'b0, 1'b0);
    chk("one_stream", {o1_node_valid, o1_phase, o1_step_done}, 3'b110);
    tick(1'b0, 1'b0, 1'b0);
    chk("one_step_end", {o1_node_valid, o1_step_done, o1_time_count, o1_done}, 4'b0110);
    tick(1'b0, 1'b0, 1'b0);
    chk("one_done", {o1_done, o1_busy, o1_step_done, o1_time_count}, 4'b1001);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
    chk("one_done_hold", {o1_done, o1_time_count}, 2'b11);

`ifdef LBM_SEQ_PAUSE_EN
    // Pause after the (0,0) transfer freezes the offer of (1,0).
    exp_q.push_back(enc(0, 0, 0));
    exp_q.push_back(enc(0, 0, 1));
    tick(1'b1, 1'b1, 1'b0);
    pause = 1'b1;
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("pause_hold", {o_node_valid, o_node_y, o_node_x}, {1'b0, 1'b0, 2'd1});
      if (i < 3) tick(1'b1, 1'b0, 1'b0);
    end
    pause = 1'b0;
    tick(1'b1, 1'b0, 1'b0);
    chk("pause_resume", {o_node_valid, o_node_y, o_node_x}, {1'b1, 1'b0, 2'd1});
    tick(1'b1, 1'b0, 1'b0);
    chk("pause_q_empty", exp_q.size(), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lbm_step_sequencer.md
LBM_STEP_SEQUENCER -- requirements
Module: lbm_step_sequencer

Interface
REQ-001 Parameter GRID_W, default 4: lattice width in nodes; legal range ≥1.
REQ-002 Parameter GRID_H, default 4: lattice height in nodes; legal range ≥1.
REQ-003 Parameter MAX_TIME, default 8: number of time steps per run.
REQ-004 Derived widths: XW = max(1,$clog2(GRID_W)), YW = max(1,$clog2(GRID_H)), TW = $clog2(MAX_TIME).
REQ-005 Clk  in  1  single clock; all state changes on rising edge.
REQ-006 Reset  in  1  asynchronous, active-high reset.
REQ-007 Start  in  1  level sampled in IDLE/DONE; launches a run.
REQ-008 Node_ack  in  1  compute engine accepted the current node.
REQ-009 Node_valid  out  1  node address and Phase valid.
REQ-010 Node_x  out  XW  current node column.
REQ-011 Node_y  out  YW  current node row.
REQ-012 Phase  out  1  0 = collide, 1 = stream.
REQ-013 Step_done  out  1  one-cycle pulse at end of each time step; drives the time-step counter Enable.
REQ-014 Time_count  out  TW+1  completed steps, saturating at MAX_TIME.
REQ-015 Busy  out  1  high in COLLIDE, STREAM, STEP_END.
REQ-016 Done  out  1  high while in DONE.

Function
REQ-017 FSM states: IDLE, COLLIDE, STREAM, STEP_END, DONE.
REQ-018 IDLE: Start=1 -> COLLIDE next cycle, Node_x=Node_y=0, Time_count=0.
REQ-019 COLLIDE/STREAM: Node_valid=1; a transfer occurs on a cycle with Node_valid=1 and Node_ack=1.
REQ-020 Node_x, Node_y, Phase SHALL remain stable while Node_valid=1 and Node_ack=0.
REQ-021 On transfer: Node_x increments; at GRID_W-1 wraps to 0 and Node_y increments; transfer at (GRID_W-1,GRID_H-1) wraps both to 0 and ends the phase.
REQ-022 End of COLLIDE -> STREAM next cycle; Node_valid stays high (no bubble).
REQ-023 End of STREAM -> STEP_END; Node_valid=0 in STEP_END.
REQ-024 STEP_END lasts exactly one cycle: Step_done=1, Time_count increments by 1 (saturate at MAX_TIME).
REQ-025 After STEP_END: new Time_count == MAX_TIME -> DONE, else -> COLLIDE.
REQ-026 DONE: Done=1, Time_count holds; Start=1 -> COLLIDE, Time_count cleared to 0, node address 0.
REQ-027 Node_ack when Node_valid=0 SHALL be ignored.
REQ-028 Start while Busy=1 SHALL be ignored.
REQ-029 GRID_W=GRID_H=1: each phase is a single transfer; step length = 3 cycles with zero-wait ack.
REQ-030 Minimum step latency with Node_ack tied high: 2·GRID_W·GRID_H + 1 cycles.
REQ-031 Time_count SHALL never exceed MAX_TIME.

Reset
REQ-032 Reset=1 asynchronously forces IDLE, Node_x=0, Node_y=0, Phase=0, Time_count=0, Node_valid=0, Step_done=0, Busy=0, Done=0.
REQ-033 Reset asserted mid-phase SHALL abort the run with no Step_done pulse; release returns to IDLE awaiting Start.

Configuration
REQ-034 Macro LBM_SEQ_PAUSE_EN defined: add input Pause (1 bit); Pause=1 in COLLIDE/STREAM while Node_valid=0-eligible (i.e. after a transfer or on entry) holds Node_valid=0 and freezes state/address; Pause never drops Node_valid already asserted without a transfer.
REQ-035 Macro LBM_SEQ_PAUSE_EN undefined: no Pause port; behaviour exactly as REQ-017..REQ-031.

Verification
REQ-036 GRID 4x2, MAX_TIME=3, Node_ack=1, Start pulse -> 8 collide then 8 stream transfers in raster order, Step_done every 17 cycles, Done after Time_count=3.
REQ-037 Node_ack held 0 for 5 cycles at node (2,1) collide -> address/Phase stable, Node_valid=1 throughout, advance to (3,1) after ack.
REQ-038 Reset asserted at stream node (1,0) of step 2 -> all outputs 0 immediately, no Step_done, IDLE after release.
REQ-039 Start in DONE (Time_count=3) -> Time_count=0, COLLIDE at (0,0) next cycle; Start during STREAM -> no effect.
REQ-040 GRID 1x1, MAX_TIME=1 -> one collide, one stream transfer, Step_done, Done; Time_count=1 and stays 1.
REQ-041 With LBM_SEQ_PAUSE_EN, Pause=1 for 4 cycles after transfer at (0,0) -> Node_valid=0, address (1,0) frozen, resumes on Pause=0.
